// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported synchronous RAM between instruction fetch (I) and load/store (D).
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of fixed D-over-I priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic              d_err,
    output logic [DATA_W-1:0] rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [2:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a requester holds req until it sees gnt in the same cycle;
    // gnt is only ever raised in IDLE, and exactly one rvalid pulse follows each gnt.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_owner_d;
    logic              r_store;
    logic              r_m_en;
    logic              r_m_we;
    logic [2:0]        r_m_size;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_i_rvalid;
    logic              r_d_rvalid;
    logic              r_d_err;

    logic w_idle;
    logic w_d_win;
    logic w_i_win;
    logic w_misalign;

    assign w_idle = (r_state == S_IDLE);

`ifdef MEM_ARB_RR_EN
    logic r_last_d;

    // On a tie, D wins only if I took the previous grant.
    assign w_d_win = d_req & (~i_req | ~r_last_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_d <= 1'b1;
        end else if (d_gnt) begin
            r_last_d <= 1'b1;
        end else if (i_gnt) begin
            r_last_d <= 1'b0;
        end
    end
`else
    assign w_d_win = d_req;
`endif

    assign w_i_win = i_req & ~w_d_win;
    assign d_gnt   = w_idle & w_d_win;
    assign i_gnt   = w_idle & w_i_win;

    assign w_misalign = ((d_size[1:0] == 2'b01) & d_addr[0]) |
                        ((d_size[1:0] == 2'b10) & (d_addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_owner_d  <= 1'b0;
            r_store    <= 1'b0;
            r_m_en     <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_size   <= 3'b000;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_rdata    <= '0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_d_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (d_gnt) begin
                        r_owner_d <= 1'b1;
                        r_store   <= d_we;
                        if (w_misalign) begin
                            // Rejected without a RAM access; respond next cycle.
                            r_state    <= S_RESP;
                            r_d_rvalid <= 1'b1;
                            r_d_err    <= 1'b1;
                        end else begin
                            r_state   <= S_ISSUE;
                            r_m_en    <= 1'b1;
                            r_m_we    <= d_we;
                            r_m_size  <= d_size;
                            r_m_addr  <= d_addr;
                            r_m_wdata <= d_wdata;
                        end
                    end else if (i_gnt) begin
                        r_owner_d <= 1'b0;
                        r_store   <= 1'b0;
                        r_state   <= S_ISSUE;
                        r_m_en    <= 1'b1;
                        r_m_we    <= 1'b0;
                        r_m_size  <= 3'b010;
                        r_m_addr  <= i_addr;
                    end
                end
                S_ISSUE: begin
                    r_m_en  <= 1'b0;
                    r_m_we  <= 1'b0;
                    r_cnt   <= LAT_M1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_store) begin
                            r_rdata <= m_rdata;
                        end
                        if (r_owner_d) begin
                            r_d_rvalid <= 1'b1;
                            r_d_err    <= 1'b0;
                        end else begin
                            r_i_rvalid <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_i_rvalid <= 1'b0;
                    r_d_rvalid <= 1'b0;
                    r_d_err    <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m_en        = r_m_en;
    assign m_we        = r_m_we;
    assign m_size      = r_m_size;
    assign m_addr      = r_m_addr;
    assign m_wdata     = r_m_wdata;
    assign rdata       = r_rdata;
    assign i_rvalid    = r_i_rvalid;
    assign d_rvalid    = r_d_rvalid;
    assign d_err       = r_d_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions on a MEM_LAT=1
// instance plus hand sequences for contention, mid-transaction reset and MEM_LAT=4.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req, d_req, i_req4, d_req4;
  logic [13:0] i_addr, d_addr;
  logic        d_we;
  logic [2:0]  d_size;
  logic [31:0] d_wdata;
  logic [31:0] m_rdata, m_rdata4;

  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, m_en, m_we;
  logic [31:0] rdata, m_wdata;
  logic [2:0]  m_size;
  logic [13:0] m_addr;
  logic [1:0]  dbg_state;

  logic        i_gnt4, i_rvalid4, d_gnt4, d_rvalid4, d_err4, m_en4, m_we4;
  logic [31:0] rdata4, m_wdata4;
  logic [2:0]  m_size4;
  logic [13:0] m_addr4;
  logic [1:0]  dbg_state4;

  int n_cmp;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .rdata(rdata),
    .m_en(m_en), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .o_dbg_state(dbg_state)
  );

  mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .MEM_LAT(4)) dut4 (
    .clk(clk), .reset(reset),
    .i_req(i_req4), .i_addr(i_addr), .i_gnt(i_gnt4), .i_rvalid(i_rvalid4),
    .d_req(d_req4), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt4), .d_rvalid(d_rvalid4), .d_err(d_err4), .rdata(rdata4),
    .m_en(m_en4), .m_we(m_we4), .m_size(m_size4), .m_addr(m_addr4), .m_wdata(m_wdata4),
    .m_rdata(m_rdata4), .o_dbg_state(dbg_state4)
  );

  // ---------------- RAM model (one-cycle synchronous read) ----------------
  logic [31:0] mem [0:255];
  logic [31:0] ram_q;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h00500093;
    mem[5] = 32'h00000013;
  end

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr[9:2]] <= m_wdata;
      ram_q <= mem[m_addr[9:2]];
    end
  end

  assign m_rdata = ram_q;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_d;
    logic        we;
    logic [2:0]  size;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_msize;
  } vec_t;

  vec_t vecs [10];

  // Starts in IDLE at a sample point; ends at a sample point back in IDLE.
  task automatic run_vec(input vec_t v, input int k);
    int  cyc;
    bit  seen_men;
    bit  got;
    if (v.is_d) begin
      i_req = 1'b0; d_req = 1'b1; d_we = v.we; d_size = v.size;
      d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      d_req = 1'b0; i_req = 1'b1; i_addr = v.addr; d_we = 1'b1; d_size = 3'b000;
    end
    #1;
    chk($sformatf("v%0d_gnt", k), 32'({i_gnt, d_gnt}), v.is_d ? 32'd1 : 32'd2);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    #1;
    cyc = 1; seen_men = 0; got = 0;
    while (!got && cyc <= 20) begin
      if (m_en) seen_men = 1;
      if (cyc == 1 && !v.exp_err) begin
        chk($sformatf("v%0d_m_we", k), 32'(m_we), 32'(v.is_d & v.we));
        chk($sformatf("v%0d_m_size", k), 32'(m_size), 32'(v.exp_msize));
        chk($sformatf("v%0d_m_addr", k), 32'(m_addr), 32'(v.addr));
        if (v.is_d && v.we) chk($sformatf("v%0d_m_wdata", k), m_wdata, v.wdata);
      end
      if (i_rvalid || d_rvalid) begin
        got = 1;
        chk($sformatf("v%0d_latency", k), 32'(cyc), v.exp_err ? 32'd1 : 32'd3);
        chk($sformatf("v%0d_rvalid", k), 32'({i_rvalid, d_rvalid}), v.is_d ? 32'd1 : 32'd2);
        chk($sformatf("v%0d_d_err", k), 32'(d_err), 32'(v.exp_err));
        chk($sformatf("v%0d_rdata", k), rdata, v.exp_rdata);
      end else begin
        tick();
        cyc++;
      end
    end
    if (!got) chk($sformatf("v%0d_timeout", k), 32'd0, 32'd1);
    chk($sformatf("v%0d_m_en_seen", k), 32'(seen_men), 32'(!v.exp_err));
    tick();
    chk($sformatf("v%0d_rvalid_one_cycle", k), 32'({i_rvalid, d_rvalid}), 32'd0);
    chk($sformatf("v%0d_back_idle", k), 32'(dbg_state), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int         n;
    int         gcyc [3];
    logic [2:0] owners;
    logic [2:0] exp_owners;
    int         both_gnt, both_rv, bad_gnt4, bad_men4, bad_rv4, late_rv;

    n_cmp = 0; n_fail = 0;
    reset = 1'b1;
    i_req = 0; d_req = 0; i_req4 = 0; d_req4 = 0;
    i_addr = '0; d_addr = '0; d_we = 0; d_size = 3'b000; d_wdata = '0;
    m_rdata4 = 32'hBAD0BAD0;

    vecs[0] = '{1'b0, 1'b0, 3'b000, 14'h0010, 32'h0,        1'b0, 32'h00500093, 3'b010};
    vecs[1] = '{1'b1, 1'b1, 3'b010, 14'h0100, 32'hDEADBEEF, 1'b0, 32'h00500093, 3'b010};
    vecs[2] = '{1'b1, 1'b0, 3'b010, 14'h0100, 32'h0,        1'b0, 32'hDEADBEEF, 3'b010};
    vecs[3] = '{1'b1, 1'b0, 3'b001, 14'h0103, 32'h0,        1'b1, 32'hDEADBEEF, 3'b001};
    vecs[4] = '{1'b1, 1'b1, 3'b010, 14'h0102, 32'h11111111, 1'b1, 32'hDEADBEEF, 3'b010};
    vecs[5] = '{1'b1, 1'b0, 3'b010, 14'h0100, 32'h0,        1'b0, 32'hDEADBEEF, 3'b010};
    vecs[6] = '{1'b1, 1'b0, 3'b000, 14'h0103, 32'h0,        1'b0, 32'hDEADBEEF, 3'b000};
    vecs[7] = '{1'b0, 1'b0, 3'b000, 14'h0014, 32'h0,        1'b0, 32'h00000013, 3'b010};
    vecs[8] = '{1'b1, 1'b1, 3'b001, 14'h0202, 32'h0000ABCD, 1'b0, 32'h00000013, 3'b001};
    vecs[9] = '{1'b1, 1'b0, 3'b101, 14'h0202, 32'h0,        1'b0, 32'h0000ABCD, 3'b101};

    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_state", 32'(dbg_state), 32'd0);
    chk("reset_ctrl", 32'({m_en, m_we, m_size, i_rvalid, d_rvalid, d_err}), 32'd0);
    chk("reset_m_addr", 32'(m_addr), 32'd0);
    chk("reset_m_wdata", m_wdata, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_state4", 32'(dbg_state4), 32'd0);

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

    // ---- both requesters held high for three grants ----
`ifdef MEM_ARB_RR_EN
    exp_owners = 3'b010;
`else
    exp_owners = 3'b111;
`endif
    i_req = 1; d_req = 1; d_we = 0; d_size = 3'b010; d_addr = 14'h0100; i_addr = 14'h0010;
    #1;
    n = 0; owners = 3'b000; both_gnt = 0; both_rv = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (i_gnt && d_gnt) both_gnt++;
      if (i_rvalid && d_rvalid) both_rv++;
      if (i_gnt || d_gnt) begin
        owners[n] = d_gnt;
        gcyc[n] = c;
        n++;
      end
      if (n < 3) tick();
    end
    tick();
    i_req = 0; d_req = 0;
    #1;
    for (int c = 0; c < 20 && dbg_state != 2'd0; c++) begin
      if (i_rvalid && d_rvalid) both_rv++;
      tick();
    end
    chk("cont_grants", 32'(n), 32'd3);
    chk("cont_order", 32'(owners), 32'(exp_owners));
    chk("cont_spacing01", 32'(gcyc[1] - gcyc[0]), 32'd4);
    chk("cont_spacing12", 32'(gcyc[2] - gcyc[1]), 32'd4);
    chk("cont_both_gnt", 32'(both_gnt), 32'd0);
    chk("cont_both_rvalid", 32'(both_rv), 32'd0);
    chk("cont_idle", 32'(dbg_state), 32'd0);

    // ---- reset asserted at T+2 of a fetch ----
    i_req = 1; i_addr = 14'h0010;
    #1;
    chk("rst_gnt", 32'(i_gnt), 32'd1);
    tick();
    i_req = 0;
    tick();
    reset = 1'b1;
    #1;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_ctrl", 32'({m_en, m_we, i_rvalid, d_rvalid, d_err}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    tick();
    reset = 1'b0;
    late_rv = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (i_rvalid || d_rvalid) late_rv++;
    end
    chk("rst_no_rvalid", 32'(late_rv), 32'd0);
    run_vec(vecs[7], 10);

    // ---- MEM_LAT=4 load word, I request waiting behind it ----
    d_req4 = 1; d_we = 0; d_size = 3'b010; d_addr = 14'h0200;
    #1;
    chk("lat4_d_gnt", 32'(d_gnt4), 32'd1);
    bad_gnt4 = 0; bad_men4 = 0; bad_rv4 = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      d_req4 = 0; i_req4 = 1;
      m_rdata4 = (c == 5) ? 32'h12345678 : 32'hBAD0BAD0;
      #1;
      if (i_gnt4 || d_gnt4) bad_gnt4++;
      if (m_en4 != (c == 1)) bad_men4++;
      if (c == 1) chk("lat4_m_addr", 32'(m_addr4), 32'h0200);
      if (c == 6) begin
        chk("lat4_d_rvalid", 32'(d_rvalid4), 32'd1);
        chk("lat4_rdata", rdata4, 32'h12345678);
        chk("lat4_d_err", 32'(d_err4), 32'd0);
      end else if (d_rvalid4 || i_rvalid4) begin
        bad_rv4++;
      end
    end
    chk("lat4_no_gnt_busy", 32'(bad_gnt4), 32'd0);
    chk("lat4_m_en_once", 32'(bad_men4), 32'd0);
    chk("lat4_no_early_rvalid", 32'(bad_rv4), 32'd0);
    tick();
    chk("lat4_i_gnt_next", 32'(i_gnt4), 32'd1);
    tick();
    i_req4 = 0;
    #1;
    for (int c = 0; c < 20 && dbg_state4 != 2'd0; c++) tick();
    chk("lat4_idle", 32'(dbg_state4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
